// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fifo_arb_pkg : shared types and width helpers for the FIFO write arbiter
// Rev 1.0
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int calc_idw(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int calc_cw(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin search, first set req at/after rr_ptr
// Rev 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               grant_valid,
    output logic [IDW-1:0]     grant_idx
);

    logic [NUM_REQ-1:0] w_masked;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign w_masked[gi] = req[gi] & (IDW'(gi) >= rr_ptr);
        end
    endgenerate

    // Unmasked search is the wrap-around fallback; masked hit overrides it.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = IDW'(i);
        end
        if (|w_masked) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_masked[i]) grant_idx = IDW'(i);
            end
        end
    end

    assign grant_valid = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_write_arbiter : round-robin burst arbiter for the async FIFO write port
// Rev 1.0
// ============================================================================
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_LEN  = 4,
    localparam int IDW        = calc_idw(NUM_REQ),
    localparam int CW         = calc_cw(BURST_LEN)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          wfull,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    localparam logic [CW-1:0]  c_LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [IDW-1:0] c_LAST_REQ  = IDW'(NUM_REQ - 1);

    arb_state_t     r_state;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] r_rr_ptr;
    logic [CW-1:0]  r_beat_cnt;

    logic           w_grant_valid;
    logic [IDW-1:0] w_grant_idx;
    logic           w_owner_req;
    logic           w_beat;
    logic [IDW-1:0] w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req         (req),
        .rr_ptr      (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    assign w_owner_req = req[r_owner];
    assign busy        = (r_state == BURST);
    assign w_beat      = busy & w_owner_req & ~wfull;
    assign winc        = w_beat;
    assign grant_id    = r_owner;
    assign wdata       = req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    assign w_next_ptr  = (r_owner == c_LAST_REQ) ? '0 : r_owner + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign ack[gi] = w_beat & (r_owner == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner    <= w_grant_idx;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    // A dropped request releases at once; full only stalls.
                    if (!w_owner_req) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= w_next_ptr;
                    end else if (!wfull) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_next_ptr;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_write_arbiter : scoreboard bench for fifo_write_arbiter (4 req, 8b)
// Rev 1.0
// ============================================================================
module tb_fifo_write_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        wfull;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .wfull    (wfull),
        .ack      (ack),
        .winc     (winc),
        .wdata    (wdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req_v);
        end
    endfunction

    // Monitor: every FIFO write must match the head of the expected queue.
    always @(negedge wclk) begin
        exp_t       e;
        logic [3:0] onehot;
        if (wrst_n && winc) begin
            wcount++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got id %0d data %0h required none", grant_id, wdata);
            end else begin
                e      = exp_q.pop_front();
                onehot = 4'b0001 << e.id;
                chk("write_id", 32'(grant_id), 32'(e.id));
                chk("write_data", 32'(wdata), 32'(e.data));
                chk("write_ack", 32'(ack), 32'(onehot));
            end
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic run_src(input int id, input logic [7:0] base, input int nbeats,
                           input int stall_after, input int stall_len, output int span);
        int   n;
        int   c;
        int   first;
        int   last;
        logic a;
        n = 0; c = 0; first = 0; last = 0;
        req_data[id*8 +: 8] = base;
        req[id] = 1'b1;
        for (int j = 0; j < nbeats; j++) exp_q.push_back('{id, base + 8'(j)});
        while (n < nbeats && c < 60) begin
            @(negedge wclk);
            a = ack[id];
            if (a) begin
                if (n == 0) first = c;
                last = c;
                n++;
            end
            tick();
            c++;
            if (a) req_data[id*8 +: 8] = base + 8'(n);
            if (a && n == stall_after) begin
                wfull = 1'b1;
                repeat (stall_len) begin
                    @(negedge wclk);
                    chk("stall_winc", 32'(winc), 32'd0);
                    chk("stall_busy", 32'(busy), 32'd1);
                    chk("stall_grant", 32'(grant_id), 32'(id));
                    tick();
                end
                wfull = 1'b0;
            end
        end
        chk("beat_count", 32'(n), 32'(nbeats));
        req[id] = 1'b0;
        span = last - first;
    endtask

    initial begin
        int span;
        int w0;
        wrst_n   = 1'b0;
        req      = 4'b1111;
        req_data = 32'hA3A2_A1A0;
        wfull    = 1'b0;

        // Reset held with all requests pending
        repeat (3) tick();
        @(negedge wclk);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'hA0);

        // Fairness: four full bursts in order 0,1,2,3, then 0 again
        tick();
        wrst_n = 1'b1;
        for (int id = 0; id < 4; id++)
            for (int b = 0; b < 4; b++) exp_q.push_back('{id, 8'hA0 + 8'(id)});
        tick();
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        w0 = wcount;
        repeat (20) tick();
        chk("fair_writes", 32'(wcount - w0), 32'd16);
        chk("fair_wrap_busy", 32'(busy), 32'd1);
        chk("fair_wrap_grant", 32'(grant_id), 32'd0);
        req = 4'b0000;
        tick();
        tick();
        chk("fair_idle", 32'(busy), 32'd0);
        chk("fair_queue", 32'(exp_q.size()), 32'd0);

        // Single requester: two bursts, one idle cycle between them
        req_data = '0;
        run_src(2, 8'h10, 8, -1, 0, span);
        chk("single_span", 32'(span), 32'd8);
        chk("single_idle", 32'(busy), 32'd0);

        // Full stall after beat 2
        run_src(1, 8'h20, 4, 2, 5, span);
        chk("stall_release", 32'(busy), 32'd0);

        // Early release of owner 3 with requester 0 waiting
        req_data[7:0] = 8'h40;
        req[0] = 1'b1;
        run_src(3, 8'h30, 2, -1, 0, span);
        @(negedge wclk);
        chk("early_winc", 32'(winc), 32'd0);
        chk("early_busy", 32'(busy), 32'd1);
        chk("early_grant", 32'(grant_id), 32'd3);
        tick();
        @(negedge wclk);
        chk("early_idle", 32'(busy), 32'd0);
        chk("early_idle_winc", 32'(winc), 32'd0);
        chk("early_rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
        tick();
        chk("early_regrant_busy", 32'(busy), 32'd1);
        chk("early_regrant_id", 32'(grant_id), 32'd0);
        run_src(0, 8'h40, 4, -1, 0, span);

        // Reset asserted during beat 2 of requester 1
        begin
            logic a;
            bit   got;
            got = 1'b0;
            req_data[15:8] = 8'h60;
            req[1] = 1'b1;
            exp_q.push_back('{1, 8'h60});
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge wclk);
                a = ack[1];
                tick();
                if (a) got = 1'b1;
            end
            chk("mid_first_beat", 32'(got), 32'd1);
            req_data[15:8] = 8'h61;
            chk("mid_beat2_winc", 32'(winc), 32'd1);
            wrst_n = 1'b0;
            #1;
            chk("mid_rst_winc", 32'(winc), 32'd0);
            chk("mid_rst_busy", 32'(busy), 32'd0);
            chk("mid_rst_ack", 32'(ack), 32'd0);
            req = 4'b0101;
            req_data = 32'h00B2_00B0;
            tick();
            tick();
            wrst_n = 1'b1;
            tick();
            chk("mid_restart_busy", 32'(busy), 32'd1);
            chk("mid_restart_grant", 32'(grant_id), 32'd0);
            req = 4'b0000;
            tick();
            tick();
            chk("mid_final_idle", 32'(busy), 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the async FIFO write port among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a burst of up to BURST_LEN beats, drives the FIFO `winc`/`wdata` inputs, and stalls on the FIFO's registered `full` flag. It sits between the write-side clients and the FIFO top, alongside the write pointer logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: FIFO data width.
- BURST_LEN, 4: maximum beats per grant, 1..256.
- IDW, derived: max(1, $clog2(NUM_REQ)).
- CW, derived: max(1, $clog2(BURST_LEN)).
- wclk  in  1  write-domain clock; all logic is on posedge.
- wrst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; level, held while data is pending.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- wfull  in  1  FIFO full flag (registered, from write pointer).
- ack  out  NUM_REQ  one-hot beat-accepted strobe for the owner.
- winc  out  1  FIFO write increment.
- wdata  out  DATA_WIDTH  FIFO write data.
- grant_id  out  IDW  current owner index.
- busy  out  1  high while a burst is granted.

## Operation
- States: IDLE and BURST. Registers: state, owner, rr_ptr, beat_cnt.
- **IDLE**
  - If any req bit is set: pick the first set index at or after rr_ptr, with cyclic wrap.
  - Latch that index into owner, clear beat_cnt, and go to BURST.
  - Otherwise stay in IDLE.
- **BURST**
  - beat = req[owner] & ~wfull.
  - winc = beat. ack[owner] = beat; all other ack bits are 0.
  - wdata = req_data slice for owner in every state, so it is don't-care when winc=0.
  - On a beat with beat_cnt == BURST_LEN-1: go to IDLE, set rr_ptr = owner+1 (mod NUM_REQ).
  - On any other beat: increment beat_cnt.
  - If req[owner] is 0: release immediately. Go to IDLE, set rr_ptr = owner+1. No write happens that cycle.
  - If wfull=1 with req[owner]=1: stall. Hold beat_cnt and keep ownership. winc=0.
- winc, ack and busy are combinational from registered state, req and wfull. Arbiter writes never collide with the write pointer's internal full gating.
- busy = (state == BURST). grant_id = owner.
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - Outputs: winc=0, ack=0, busy=0, grant_id=0. wdata follows req_data slice 0.
- Reset mid-burst: asynchronous clear. winc drops in the same cycle as reset assertion. A partial burst is not resumed after reset.
- Requests from non-owners are ignored during BURST. Requesters must hold req and data stable until acked.

## Timing
- Grant latency: req rises in cycle 0 while IDLE → busy and winc high in cycle 1 (if wfull=0) → first write at the edge ending cycle 1.
- Throughput: one beat per cycle within a burst while wfull=0.
- Release costs exactly one IDLE cycle. Back-to-back bursts therefore have a 1-cycle gap on winc.
- wfull is assumed to update one cycle after the filling write, per the write pointer. The arbiter does not predict full.
- Priority rotation: the owner of the finished burst gets lowest priority on the next arbitration. Rotation is identical for max-length and early-release endings.

## Structure
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, BURST} arb_state_t;
  - localparam functions for IDW and CW.
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs grant_valid and grant_idx. It implements the masked-then-unmasked priority search and is reusable on the read side.

## Test plan
All scenarios use NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=8.
- Reset: hold wrst_n=0 with req=4'b1111 → winc=0, ack=0, busy=0, grant_id=0. Release reset → busy=1 one cycle later, grant_id=0.
- Single requester: req[2]=1 continuously, data 0x10..0x17 → two bursts of 4 acks each, with a 1-cycle gap between them. wdata sequence is 0x10..0x17, grant_id=2 throughout.
- Fairness: req=4'b1111 held → grant_id sequence 0,1,2,3,0; each burst has exactly 4 winc pulses, totalling 16 writes over 20 cycles.
- Full stall: grant to req[1], assert wfull after beat 2 for 5 cycles → winc=0 while full, busy=1, grant_id=1. Beats 3–4 complete after wfull drops, then release.
- Early release: req[3] drops after 2 beats while req[0]=1 → IDLE for 1 cycle, then grant_id=0 and rr_ptr=0. No winc while req[3]=0.
- Mid-burst reset: assert wrst_n=0 during beat 2 of req[1] → winc=0 in the same cycle. After release, arbitration restarts from rr_ptr=0.
